// File: rtl/tc_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NumReq requesters.
// Read responses are steered back through a Latency-deep {valid, idx} pipeline.
module tc_sram_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  parameter int unsigned Latency   = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    req_i,
  input  logic [NumReq-1:0]                    we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]       be_i,
  output logic [NumReq-1:0]                    gnt_o,
  output logic [NumReq-1:0]                    rvalid_o,
  output logic [DataWidth-1:0]                 rdata_o,
  output logic                                 sram_req_o,
  output logic                                 sram_we_o,
  output logic [AddrWidth-1:0]                 sram_addr_o,
  output logic [DataWidth-1:0]                 sram_wdata_o,
  output logic [BeWidth-1:0]                   sram_be_o,
  input  logic [DataWidth-1:0]                 sram_rdata_i
);

  localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [IdxWidth-1:0] rr_ptr;
  logic [IdxWidth-1:0] ptr_next;
  logic [IdxWidth-1:0] win_idx;
  logic [IdxWidth-1:0] cand_idx;
  logic                win_valid;

  logic [Latency-1:0]               pipe_valid;
  logic [Latency-1:0][IdxWidth-1:0] pipe_idx;

  // First requesting index scanning upward from rr_ptr, wrapping at NumReq.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand_idx = IdxWidth'((32'(rr_ptr) + i) % NumReq);
      if (!win_valid && req_i[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      gnt_o[k] = win_valid && (win_idx == IdxWidth'(k));
    end
  end

  assign sram_req_o = |req_i;

  always_comb begin
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (win_valid) begin
      sram_we_o    = we_i[win_idx];
      sram_addr_o  = addr_i[win_idx];
      sram_wdata_o = wdata_i[win_idx];
      sram_be_o    = be_i[win_idx];
    end
  end

  assign ptr_next = (win_idx == IdxWidth'(NumReq - 1)) ? '0 : win_idx + IdxWidth'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (win_valid) begin
      rr_ptr <= ptr_next;
    end
  end

  // Stage Latency-1 captures the granted read; stage 0 drives rvalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      pipe_idx   <= '0;
    end else begin
      pipe_valid[Latency-1] <= win_valid && !we_i[win_idx];
      pipe_idx[Latency-1]   <= win_idx;
      for (int s = 0; s < int'(Latency) - 1; s++) begin
        pipe_valid[s] <= pipe_valid[s+1];
        pipe_idx[s]   <= pipe_idx[s+1];
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      rvalid_o[k] = pipe_valid[0] && (pipe_idx[0] == IdxWidth'(k));
    end
  end

  assign rdata_o = sram_rdata_i;

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o))
    else $error("gnt_o is not onehot0");
  a_rvalid_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rvalid_o))
    else $error("rvalid_o is not onehot0");
  a_gnt_implies_req : assert property (@(posedge clk_i) disable iff (rst_i) ((gnt_o & ~req_i) == '0))
    else $error("gnt_o asserted without matching req_i");

endmodule

// File: doc/tc_sram_arbiter.md
Name: tc_sram_arbiter

Overview:
Round-robin arbiter and sequencer that shares one port of a generic single-port SRAM macro between NumReq requesters.
Each requester uses a req/gnt request channel and gets an rvalid response channel.
The block issues at most one SRAM access per cycle. It tracks in-flight reads through a Latency-deep pipeline, so read data is returned to the requester that issued it.
It sits directly in front of one SRAM port in memory-subsystem and cluster TCDM tiles.

Parameters:
NumReq, 4, number of requesters (>=1)
AddrWidth, 10, word address width
DataWidth, 32, data width
ByteWidth, 8, bits per byte-enable bit
BeWidth, ceil(DataWidth/ByteWidth), derived; do not override
Latency, 1, read latency of the attached SRAM port in cycles (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is asynchronous and active-high
req_i  in  NumReq  per-requester request
we_i  in  NumReq  per-requester write enable
addr_i  in  NumReq x AddrWidth  per-requester word address
wdata_i  in  NumReq x DataWidth  per-requester write data
be_i  in  NumReq x BeWidth  per-requester byte enable
gnt_o  out  NumReq  grant, one-hot or zero
rvalid_o  out  NumReq  read data valid, one-hot or zero
rdata_o  out  DataWidth  read data, broadcast to all requesters
sram_req_o  out  1  SRAM request
sram_we_o  out  1  SRAM write enable
sram_addr_o  out  AddrWidth  SRAM address
sram_wdata_o  out  DataWidth  SRAM write data
sram_be_o  out  BeWidth  SRAM byte enable
sram_rdata_i  in  DataWidth  SRAM read data, valid Latency cycles after a read request

Behaviour:
- Grant is combinational in the same cycle.
  - Winner = first requester with req_i high, scanning upward from rr_ptr and wrapping NumReq-1 -> 0.
  - gnt_o = one-hot of the winner; all zero if no req_i is high.
  - A transfer is complete on req_i[k] & gnt_o[k] at a rising edge.
- rr_ptr register:
  - Reset value 0.
  - On a transfer to k, rr_ptr <= (k+1) mod NumReq.
  - No transfer -> rr_ptr holds.
  - NumReq=1: ptr is constant 0 and gnt_o = req_i.
- SRAM drive, combinational:
  - sram_req_o = |req_i.
  - sram_we_o, sram_addr_o, sram_wdata_o and sram_be_o are muxed from the winner.
  - All four are zero when no request is present.
- Response pipeline:
  - Latency stages, each holding {valid, idx[clog2(NumReq) or 1 bit]}.
  - Stage Latency-1 loads {transfer & ~we, winner}; each stage shifts toward stage 0 every cycle.
  - rvalid_o[idx0] = valid0; all other rvalid_o bits are 0.
  - rdata_o = sram_rdata_i, passed through unregistered.
- Writes produce no rvalid.
- Back-to-back reads from one or several requesters sustain 1 access/cycle. Responses come out in grant order, each exactly Latency cycles after its grant edge.
- Requester protocol: once req_i[k] is asserted, req/we/addr/wdata/be stay stable until granted. A bench assertion flags violations; the RTL behaviour on a violation is undefined.
- Fairness: with all requesters asserting continuously, each is granted once every NumReq cycles.
- Reset:
  - Asserting rst_i at any time clears rr_ptr and all pipeline valid bits asynchronously.
  - rvalid_o = 0 during reset and in the first cycle after release.
  - In-flight reads are dropped with no response.
  - gnt_o and sram_* remain combinational and are not gated by reset.
- Out-of-range address: passed through unchanged; the SRAM model warns.
- Implementation assertions: gnt_o onehot0, rvalid_o onehot0, and gnt_o[k] implies req_i[k].

Test Plan:
1. NumReq=4, Latency=1. Single read by req 2 at addr 0x10, with SRAM preloaded 0x10=0xDEADBEEF.
   -> gnt_o=4'b0100 in the same cycle. The next cycle gives rvalid_o=4'b0100 and rdata_o=0xDEADBEEF.
2. All four requesters read continuously for 8 cycles.
   -> gnt_o sequence 0001,0010,0100,1000,0001,...
   -> rvalid_o repeats the same sequence 1 cycle later; no idle cycles.
3. Req 1 writes 0xCAFEF00D to addr 3 with be=4'b0011, over old value 0x11223344. Req 1 then reads addr 3.
   -> No rvalid for the write. The read returns 0x1122F00D.
4. Latency=3, reads granted to req 0,3,1 in consecutive cycles.
   -> rvalid_o = 0001,1000,0010 on cycles +3,+4,+5 after the first grant.
5. Reset pulse asserted asynchronously while 2 reads are in flight (Latency=3).
   -> No rvalid after reset, and rr_ptr returns to 0. The next simultaneous req 0 and req 2 grants req 0.
6. Only req 3 requests after a grant to req 3 (rr_ptr=0).
   -> Wrap-around scan grants req 3 again in the same cycle.
